// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 16;
  localparam int DEF_AW    = $clog2(DEF_NREGS);
  // Slot served by the datapath PC value instead of storage.
  localparam int PC_IDX    = DEF_NREGS - 1;

  typedef logic [DEF_AW-1:0]    reg_addr_t;
  typedef logic [DEF_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Load scoreboard: one pending bit per stored register, set on load issue,
// cleared by load writeback, with set taking priority for back-to-back loads.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_dest,
  input  logic          we4,
  input  logic [AW-1:0] wa4,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] ra3,
  output logic          busy1,
  output logic          busy2,
  output logic          busy3,
  output logic          iss_ok
);

  localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

  // The PC bit is never set, so every lookup of PC_ADDR reads as not pending.
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             clr_hit_s;

  assign clr_hit_s = we4 && (wa4 != PC_ADDR);

  // Next pending vector: clear from load writeback first, then issue sets on top.
  always_comb begin
    pending_d = pending_q;
    if (clr_hit_s) begin
      pending_d[wa4] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (iss_valid && (iss_dest != PC_ADDR)) begin
      pending_d[iss_dest] = 1'b1;
    end else begin
      pending_d[PC_ADDR] = 1'b0;
    end
  end

  // Pending-bit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A writeback landing this cycle releases the register immediately.
  always_comb begin
    busy1  = pending_q[ra1] && !(we4 && (wa4 == ra1)) && (ra1 != PC_ADDR);
    busy2  = pending_q[ra2] && !(we4 && (wa4 == ra2)) && (ra2 != PC_ADDR);
    busy3  = pending_q[ra3] && !(we4 && (wa4 == ra3)) && (ra3 != PC_ADDR);
    iss_ok = !pending_q[iss_dest] || (we4 && (wa4 == iss_dest));
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, three-read register file with same-cycle bypass, PC slot served
// from the datapath, and a load scoreboard for dependent-read stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  input  logic [WIDTH-1:0] r15,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_dest,
  output logic             iss_ok,
  output logic             wr_conflict
);

  localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

  // Only NREGS-1 entries: the PC index has no storage behind it.
  logic [WIDTH-1:0] mem_q [NREGS-1];
  logic [WIDTH-1:0] mem_d [NREGS-1];
  logic             wr_conflict_q;
  logic             wr_conflict_d;
  logic [AW-1:0]    ra_s [3];
  logic [WIDTH-1:0] rd_s [3];

  assign ra_s[0] = ra1;
  assign ra_s[1] = ra2;
  assign ra_s[2] = ra3;

  // Write arbitration: port B (load) beats port A on a shared address.
  // The loop never reaches PC_ADDR, so PC writes fall away naturally.
  always_comb begin
    for (int i = 0; i < NREGS - 1; i++) begin
      if (we4 && (wa4 == AW'(i))) begin
        mem_d[i] = wd4;
      end else if (we3 && (wa3 == AW'(i))) begin
        mem_d[i] = wd3;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Collision flag for the next cycle; PC writes are not real writes.
  always_comb begin
    wr_conflict_d = we3 && we4 && (wa3 == wa4) && (wa3 != PC_ADDR);
  end

  // Storage and conflict register, synchronous reset wins over writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q         <= '{default: '0};
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Read muxes: PC, then load bypass, then ALU bypass, then storage.
  always_comb begin
    rd_s = '{default: '0};
    for (int p = 0; p < 3; p++) begin
      if (ra_s[p] == PC_ADDR) begin
        rd_s[p] = r15;
      end else if (we4 && (wa4 == ra_s[p])) begin
        rd_s[p] = wd4;
      end else if (we3 && (wa3 == ra_s[p])) begin
        rd_s[p] = wd3;
      end else begin
        rd_s[p] = mem_q[ra_s[p]];
      end
    end
  end

  assign rd1         = rd_s[0];
  assign rd2         = rd_s[1];
  assign rd3         = rd_s[2];
  assign wr_conflict = wr_conflict_q;

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_valid(iss_valid),
    .iss_dest (iss_dest),
    .we4      (we4),
    .wa4      (wa4),
    .ra1      (ra1),
    .ra2      (ra2),
    .ra3      (ra3),
    .busy1    (busy1),
    .busy2    (busy2),
    .busy3    (busy3),
    .iss_ok   (iss_ok)
  );

endmodule
